// File: rtl/anton_common_pkg.sv
// rtl/anton_common_pkg.sv - shared state encoding and defaults for the neopixel frame scheduler
//
// Purpose: one place for the scheduler FSM encoding and the default widths and
// timeouts, so the top and its counter agree.
// Ports: none (package).

package anton_common;

    localparam int PERIOD_WIDTH_DEF  = 24;
    localparam int START_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_ARM    = 3'd2,
        ST_STREAM = 3'd3,
        ST_COUNT  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/anton_frame_period_counter.sv
// rtl/anton_frame_period_counter.sv - loadable saturating frame-period counter with compare
//
// Purpose: counts cycles since the current frame launched and reports when the
// programmed period has been reached.
// Ports:
//   clk, rst  - block clock, asynchronous active-high reset
//   load      - force the count to 1 (asserted on the edge entering a frame launch)
//   inc       - advance the count by one, saturating at all-ones
//   target    - period to compare against
//   reached   - count is at or beyond target

module anton_frame_period_counter
    import anton_common::*;
#(
    parameter int WIDTH = PERIOD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic             reached
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = WIDTH'(1);
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // ">=" rather than "==" so a frame that overstays in ARM still releases
    // COUNT immediately instead of waiting for the counter to saturate.
    assign reached = (count_q >= target);

endmodule

// File: rtl/anton_neopixel_frame_scheduler.sv
// rtl/anton_neopixel_frame_scheduler.sv - frame launch, page flip and stream tracking for the neopixel datapath
//
// Purpose: launches each LED frame with a one-cycle syncStart at a programmable
// period, watches neoBusy to completion, flips the display page only at a frame
// launch and records overrun / start-failure sticky flags.
// Optional feature macro: ANTON_FRAME_STATS_EN (frameCount / overrunCount registers).
// Ports:
//   clk6_4mhz, reset - block clock, asynchronous active-high reset
//   enable           - run the frame schedule
//   periodTicks      - cycles between frame launches (0 or 1 = free-running)
//   neoBusy          - streamer busy (data plus reset delay)
//   swapReq          - CPU page-flip request, held until swapAck
//   clearFlags       - clears overrun and startFail
//   syncStart        - registered frame launch pulse
//   bufferSel        - page currently displayed
//   swapAck          - flip applied (coincides with syncStart)
//   overrun          - sticky: period elapsed while streaming
//   startFail        - sticky: neoBusy never rose after a launch
//   frameCount       - frames launched (stats build, else 0)
//   overrunCount     - overrun events (stats build, else 0)

module anton_neopixel_frame_scheduler
    import anton_common::*;
#(
    parameter int PERIOD_WIDTH  = PERIOD_WIDTH_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                    clk6_4mhz,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] periodTicks,
    input  logic                    neoBusy,
    input  logic                    swapReq,
    input  logic                    clearFlags,
    output logic                    syncStart,
    output logic                    bufferSel,
    output logic                    swapAck,
    output logic                    overrun,
    output logic                    startFail,
    output logic [15:0]             frameCount,
    output logic [15:0]             overrunCount
);

    localparam int ARM_W = $clog2(START_TIMEOUT + 1);

    sched_state_t state_q, state_d;
    logic             sync_start_q, sync_start_d;
    logic             swap_ack_q, swap_ack_d;
    logic             buffer_sel_q, buffer_sel_d;
    logic             overrun_q, overrun_d;
    logic             start_fail_q, start_fail_d;
    logic             ovr_frame_q, ovr_frame_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

    logic overrun_set;
    logic start_fail_set;
    logic period_reached;
    logic free_run;

    assign free_run = (periodTicks[PERIOD_WIDTH-1:1] == '0);

    // Loading on the edge into START makes the count read 1 during START, so
    // COUNT leaves when count == periodTicks and launches land exactly
    // periodTicks cycles apart.
    anton_frame_period_counter #(
        .WIDTH (PERIOD_WIDTH)
    ) u_period (
        .clk     (clk6_4mhz),
        .rst     (reset),
        .load    (state_d == ST_START),
        .inc     (state_q != ST_IDLE),
        .target  (periodTicks),
        .reached (period_reached)
    );

    always_comb begin
        state_d        = state_q;
        ovr_frame_d    = ovr_frame_q;
        arm_cnt_d      = '0;
        overrun_set    = 1'b0;
        start_fail_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                ovr_frame_d = 1'b0;
                state_d     = ST_ARM;
            end
            ST_ARM: begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (neoBusy) begin
                    state_d = ST_STREAM;
                end else if (arm_cnt_q == ARM_W'(START_TIMEOUT - 1)) begin
                    start_fail_set = 1'b1;
                    state_d        = ST_COUNT;
                end
            end
            ST_STREAM: begin
                // ovr_frame_q limits the overrun event to once per frame.
                if (period_reached && !free_run && !ovr_frame_q) begin
                    overrun_set = 1'b1;
                    ovr_frame_d = 1'b1;
                end
                if (!neoBusy) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (ovr_frame_q || overrun_set || free_run) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (free_run || period_reached) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulses and the page flip are registered from the next state so they
        // are all high exactly during the START cycle.
        sync_start_d = (state_d == ST_START);
        swap_ack_d   = sync_start_d && swapReq;
        buffer_sel_d = buffer_sel_q ^ swap_ack_d;

        // A set event in the same cycle as clearFlags wins.
        overrun_d    = overrun_set    | (overrun_q    & ~clearFlags);
        start_fail_d = start_fail_set | (start_fail_q & ~clearFlags);
    end

    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sync_start_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            buffer_sel_q <= 1'b0;
            overrun_q    <= 1'b0;
            start_fail_q <= 1'b0;
            ovr_frame_q  <= 1'b0;
            arm_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sync_start_q <= sync_start_d;
            swap_ack_q   <= swap_ack_d;
            buffer_sel_q <= buffer_sel_d;
            overrun_q    <= overrun_d;
            start_fail_q <= start_fail_d;
            ovr_frame_q  <= ovr_frame_d;
            arm_cnt_q    <= arm_cnt_d;
        end
    end

    assign syncStart = sync_start_q;
    assign swapAck   = swap_ack_q;
    assign bufferSel = buffer_sel_q;
    assign overrun   = overrun_q;
    assign startFail = start_fail_q;

`ifdef ANTON_FRAME_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] overrun_count_q, overrun_count_d;

    always_comb begin
        frame_count_d   = frame_count_q + 16'(state_q == ST_START);
        overrun_count_d = overrun_count_q + 16'(overrun_set);
    end

    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            frame_count_q   <= '0;
            overrun_count_q <= '0;
        end else begin
            frame_count_q   <= frame_count_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    assign frameCount   = frame_count_q;
    assign overrunCount = overrun_count_q;
`else
    assign frameCount   = 16'd0;
    assign overrunCount = 16'd0;
`endif

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// tb/tb_anton_neopixel_frame_scheduler.sv - directed self-checking bench for anton_neopixel_frame_scheduler

module tb_anton_neopixel_frame_scheduler;

`ifdef ANTON_FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk6_4mhz = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] periodTicks;
    logic        neoBusy;
    logic        swapReq;
    logic        clearFlags;
    logic        syncStart;
    logic        bufferSel;
    logic        swapAck;
    logic        overrun;
    logic        startFail;
    logic [15:0] frameCount;
    logic [15:0] overrunCount;

    anton_neopixel_frame_scheduler #(
        .PERIOD_WIDTH  (24),
        .START_TIMEOUT (16)
    ) dut (
        .clk6_4mhz    (clk6_4mhz),
        .reset        (reset),
        .enable       (enable),
        .periodTicks  (periodTicks),
        .neoBusy      (neoBusy),
        .swapReq      (swapReq),
        .clearFlags   (clearFlags),
        .syncStart    (syncStart),
        .bufferSel    (bufferSel),
        .swapAck      (swapAck),
        .overrun      (overrun),
        .startFail    (startFail),
        .frameCount   (frameCount),
        .overrunCount (overrunCount)
    );

    always #5 clk6_4mhz = ~clk6_4mhz;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   busy_len = 0;
    int   syncs[$];
    int   bad_flip = 0;
    int   bad_ack  = 0;
    logic prev_sel = 1'b0;
    int   e_cyc;
    int   s0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sync_at(input int i);
        if (i < syncs.size()) return syncs[i];
        return -1;
    endfunction

    // One clock cycle: sample outputs at the falling edge, then drive the
    // streamer model: busy for busy_len cycles starting 2 cycles after launch.
    task automatic step();
        int d;
        @(negedge clk6_4mhz);
        cyc++;
        if (syncStart === 1'b1) syncs.push_back(cyc);
        if ((bufferSel !== prev_sel) && (syncStart !== 1'b1)) bad_flip++;
        if ((swapAck === 1'b1) && (syncStart !== 1'b1)) bad_ack++;
        prev_sel = bufferSel;
        if (syncs.size() == 0) begin
            neoBusy = 1'b0;
        end else begin
            d = cyc - syncs[$];
            neoBusy = (d >= 2) && (d < 2 + busy_len);
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_sync(input int n, input int budget, input string tag);
        int k = 0;
        while ((syncs.size() < n) && (k < budget)) begin
            step();
            k++;
        end
        chk(tag, (syncs.size() >= n), 1);
    endtask

    task automatic start_test(input int p, input int blen);
        enable     = 1'b0;
        swapReq    = 1'b0;
        clearFlags = 1'b0;
        reset      = 1'b1;
        step();
        step();
        reset       = 1'b0;
        syncs.delete();
        periodTicks = 24'(p);
        busy_len    = blen;
        bad_flip    = 0;
        bad_ack     = 0;
        prev_sel    = 1'b0;
        step();
        enable = 1'b1;
        e_cyc  = cyc;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        periodTicks = 24'd0;
        neoBusy     = 1'b0;
        swapReq     = 1'b0;
        clearFlags  = 1'b0;
        step();
        chk("rst_sync", syncStart, 0);
        chk("rst_sel", bufferSel, 0);
        chk("rst_ack", swapAck, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_fail", startFail, 0);
        chk("rst_fcnt", frameCount, 0);
        chk("rst_ocnt", overrunCount, 0);

        // Basic period 100, 40-cycle streams, then disable mid-stream.
        start_test(100, 40);
        wait_sync(3, 400, "basic_to");
        chk("basic_lat", sync_at(0), e_cyc + 1);
        chk("basic_gap1", sync_at(1) - sync_at(0), 100);
        chk("basic_gap2", sync_at(2) - sync_at(1), 100);
        chk("basic_ovr", overrun, 0);
        step_to(sync_at(2) + 10);
        enable = 1'b0;
        repeat (200) step();
        chk("dis_nosync", syncs.size(), 3);
        chk("dis_fcnt", frameCount, STATS ? 3 : 0);

        // Overrun: 70-cycle stream against a 50-cycle period.
        start_test(50, 70);
        wait_sync(2, 300, "ovr_to");
        chk("ovr_gap", sync_at(1) - sync_at(0), 73);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", overrunCount, STATS ? 1 : 0);
        step_to(sync_at(1) + 10);
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Free-running (periodTicks = 1): launch one cycle after busy falls.
        start_test(1, 20);
        wait_sync(3, 200, "free_to");
        chk("free_gap1", sync_at(1) - sync_at(0), 23);
        chk("free_gap2", sync_at(2) - sync_at(1), 23);
        chk("free_ovr", overrun, 0);

        // Page flip requested mid-frame, held across several frames.
        start_test(100, 40);
        wait_sync(1, 50, "flip_to0");
        chk("flip_sel0", bufferSel, 0);
        step_to(sync_at(0) + 10);
        swapReq = 1'b1;
        wait_sync(2, 200, "flip_to1");
        chk("flip_sel1", bufferSel, 1);
        chk("flip_ack1", swapAck, 1);
        wait_sync(3, 200, "flip_to2");
        chk("flip_sel2", bufferSel, 0);
        chk("flip_ack2", swapAck, 1);
        wait_sync(4, 200, "flip_to3");
        chk("flip_sel3", bufferSel, 1);
        chk("flip_ack3", swapAck, 1);
        swapReq = 1'b0;
        wait_sync(5, 200, "flip_to4");
        chk("flip_sel4", bufferSel, 1);
        chk("flip_ack4", swapAck, 0);
        chk("flip_gap", sync_at(4) - sync_at(3), 100);
        step_to(sync_at(4) + 60);
        chk("flip_badsel", bad_flip, 0);
        chk("flip_badack", bad_ack, 0);
        chk("flip_fcnt", frameCount, STATS ? 5 : 0);

        // Asynchronous reset while in COUNT.
        #2 reset = 1'b1;
        #1;
        chk("arst_sel", bufferSel, 0);
        chk("arst_sync", syncStart, 0);
        chk("arst_fcnt", frameCount, 0);
        chk("arst_ack", swapAck, 0);
        step();
        reset = 1'b0;

        // Start failure: neoBusy never rises.
        start_test(100, 0);
        wait_sync(1, 50, "fail_to0");
        s0 = sync_at(0);
        step_to(s0 + 16);
        chk("fail_early", startFail, 0);
        step();
        chk("fail_set", startFail, 1);
        step_to(s0 + 50);
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        chk("fail_clr", startFail, 0);
        wait_sync(2, 200, "fail_to1");
        chk("fail_gap", sync_at(1) - s0, 100);
        step_to(sync_at(1) + 16);
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        chk("fail_setwins", startFail, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
